// File: rtl/ucode_issue_ctrl_if.sv
// Issue-slot bundle: IF fetch side, sequencer micro-op side, ID side and status.
interface ucode_issue_ctrl_if;
    logic [31:0] if_instr;
    logic        if_valid;
    logic [31:0] ucode_instr;
    logic        ucode_mux_ctrl;
    logic        ucode_release;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        pc_stall;
    logic        ucode_start;
    logic [31:0] mul_instr;
    logic        ucode_abort;
    logic        busy;
    logic        err_timeout;
    logic        err_spurious;
    logic [15:0] uop_count;

    // Environment side: drives fetch and sequencer inputs, observes the controller.
    modport master (
        output if_instr, if_valid, ucode_instr, ucode_mux_ctrl, ucode_release,
        input  id_instr, id_valid, pc_stall, ucode_start, mul_instr, ucode_abort,
               busy, err_timeout, err_spurious, uop_count
    );

    // Controller side.
    modport slave (
        input  if_instr, if_valid, ucode_instr, ucode_mux_ctrl, ucode_release,
        output id_instr, id_valid, pc_stall, ucode_start, mul_instr, ucode_abort,
               busy, err_timeout, err_spurious, uop_count
    );
endinterface

// File: rtl/ucode_issue_ctrl.sv
// Issue-slot controller: forwards IF ops to ID, hands MUL-class ops to the microcode
// sequencer, steers its micro-ops into ID, drains, then returns the slot to IF.
module ucode_issue_ctrl #(
    parameter logic [4:0]  MUL_PREFIX   = 5'b10111,
    parameter logic [31:0] NOP_INSTR    = 32'hC800_0000,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 1024
) (
    input logic               clk,
    input logic               rst,
    ucode_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StDrain} state_e;

    localparam logic [15:0] WdogLast  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  DrainInit = 4'(DRAIN_CYCLES);

    state_e      r_state, w_state_nxt;
    logic [31:0] r_id_instr, w_id_instr_nxt;
    logic        r_id_valid, w_id_valid_nxt;
    logic [31:0] r_mul_instr, w_mul_instr_nxt;
    logic [15:0] r_uop_count, w_uop_count_nxt;
    logic [15:0] r_wdog, w_wdog_nxt;
    logic [3:0]  r_drain, w_drain_nxt;
    logic        r_err_timeout, w_err_timeout_nxt;
    logic        r_err_spurious, w_err_spurious_nxt;
    logic        w_start;
    logic        w_abort;
    logic        w_is_mul;

    assign w_is_mul = (bus.if_instr[31:27] == MUL_PREFIX);

    // State and registered outputs; async reset returns the slot to IF with a NOP in ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= StIdle;
            r_id_instr     <= NOP_INSTR;
            r_id_valid     <= 1'b0;
            r_mul_instr    <= '0;
            r_uop_count    <= '0;
            r_wdog         <= '0;
            r_drain        <= '0;
            r_err_timeout  <= 1'b0;
            r_err_spurious <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_id_instr     <= w_id_instr_nxt;
            r_id_valid     <= w_id_valid_nxt;
            r_mul_instr    <= w_mul_instr_nxt;
            r_uop_count    <= w_uop_count_nxt;
            r_wdog         <= w_wdog_nxt;
            r_drain        <= w_drain_nxt;
            r_err_timeout  <= w_err_timeout_nxt;
            r_err_spurious <= w_err_spurious_nxt;
        end
    end

    // Next-state, ID steering and the start/abort strobes.
    always_comb begin
        w_state_nxt       = r_state;
        w_id_instr_nxt    = NOP_INSTR;
        w_id_valid_nxt    = 1'b0;
        w_mul_instr_nxt   = r_mul_instr;
        w_uop_count_nxt   = r_uop_count;
        w_wdog_nxt        = r_wdog;
        w_drain_nxt       = r_drain;
        w_err_timeout_nxt = r_err_timeout;
        // Sequencer activity is only legal while it owns the slot.
        w_err_spurious_nxt = r_err_spurious |
                             ((bus.ucode_mux_ctrl | bus.ucode_release) & (r_state != StBusy));
        w_start = 1'b0;
        w_abort = 1'b0;

        case (r_state)
            StIdle: begin
                if (bus.if_valid) begin
                    if (w_is_mul) begin
                        w_mul_instr_nxt = bus.if_instr;
                        w_uop_count_nxt = '0;
                        w_state_nxt     = StLaunch;
                    end else begin
                        w_id_instr_nxt = bus.if_instr;
                        w_id_valid_nxt = 1'b1;
                    end
                end
            end
            StLaunch: begin
                w_start     = 1'b1;
                w_wdog_nxt  = '0;
                w_state_nxt = StBusy;
            end
            StBusy: begin
                if (bus.ucode_mux_ctrl) begin
                    w_id_instr_nxt = bus.ucode_instr;
                    w_id_valid_nxt = 1'b1;
                    if (r_uop_count != 16'hFFFF) begin
                        w_uop_count_nxt = r_uop_count + 16'd1;
                    end
                end
                w_wdog_nxt = r_wdog + 16'd1;
                // Release wins over a watchdog expiry in the same cycle.
                if (bus.ucode_release) begin
                    w_drain_nxt = DrainInit;
                    w_state_nxt = StDrain;
                end else if (r_wdog == WdogLast) begin
                    w_abort           = 1'b1;
                    w_err_timeout_nxt = 1'b1;
                    w_state_nxt       = StIdle;
                end
            end
            StDrain: begin
                w_drain_nxt = r_drain - 4'd1;
                if (r_drain == 4'd1) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign bus.id_instr     = r_id_instr;
    assign bus.id_valid     = r_id_valid;
    assign bus.mul_instr    = r_mul_instr;
    assign bus.uop_count    = r_uop_count;
    assign bus.err_timeout  = r_err_timeout;
    assign bus.err_spurious = r_err_spurious;
    assign bus.pc_stall     = (r_state != StIdle);
    assign bus.busy         = (r_state != StIdle);
    assign bus.ucode_start  = w_start;
    assign bus.ucode_abort  = w_abort;
endmodule

// File: tb/tb_ucode_issue_ctrl.sv
// Self-checking bench for ucode_issue_ctrl: randomized op streams and MUL sequences checked
// against expectations derived per transaction from cycle positions.
module tb_ucode_issue_ctrl;
    localparam logic [31:0] Nop     = 32'hC800_0000;
    localparam logic [4:0]  MulPfx  = 5'b10111;
    localparam int          Timeout = 8;
    localparam int          Drain   = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    // Expected sticky error flags.
    logic e_to = 1'b0;
    logic e_sp = 1'b0;

    ucode_issue_ctrl_if bus ();

    ucode_issue_ctrl #(
        .TIMEOUT(Timeout)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ii, input logic m,
                         input logic [31:0] ui, input logic r);
        bus.if_valid       = v;
        bus.if_instr       = ii;
        bus.ucode_mux_ctrl = m;
        bus.ucode_instr    = ui;
        bus.ucode_release  = r;
    endtask

    // One clock: drive, check decoded outputs mid-cycle, then check ID one edge later.
    task automatic step(input string tag, input logic v, input logic [31:0] ii, input logic m,
                        input logic [31:0] ui, input logic r, input logic x_stall,
                        input logic x_start, input logic x_abort, input logic [31:0] x_id,
                        input logic x_idv);
        drive(v, ii, m, ui, r);
        #3;
        chk({tag, ".pc_stall"}, 32'(bus.pc_stall), 32'(x_stall));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(x_stall));
        chk({tag, ".ucode_start"}, 32'(bus.ucode_start), 32'(x_start));
        chk({tag, ".ucode_abort"}, 32'(bus.ucode_abort), 32'(x_abort));
        tick();
        chk({tag, ".id_instr"}, bus.id_instr, x_id);
        chk({tag, ".id_valid"}, 32'(bus.id_valid), 32'(x_idv));
    endtask

    function automatic logic [31:0] rand_plain();
        logic [31:0] w;
        w = $urandom;
        if (w[31:27] == MulPfx) w[27] = 1'b0;
        return w;
    endfunction

    function automatic logic [31:0] rand_mul();
        logic [31:0] w;
        w = $urandom;
        w[31:27] = MulPfx;
        return w;
    endfunction

    task automatic chk_flags(input string tag);
        chk({tag, ".err_timeout"}, 32'(bus.err_timeout), 32'(e_to));
        chk({tag, ".err_spurious"}, 32'(bus.err_spurious), 32'(e_sp));
    endtask

    // A full MUL transaction. rel_at = BUSY cycle of release (1-based), 0 = sequencer silent.
    // uop_mode: 0 no micro-ops, 1 random, 2 one every BUSY cycle. Ends after drain/abort.
    task automatic run_mul(input string tag, input int rel_at, input int uop_mode);
        logic [31:0] mul;
        logic [31:0] ui;
        logic        m;
        logic        r;
        logic        ab;
        int          cnt;
        int          last;
        mul = rand_mul();
        step({tag, ".detect"}, 1'b1, mul, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, Nop, 1'b0);
        chk({tag, ".mul_instr"}, bus.mul_instr, mul);
        chk({tag, ".uop_clr"}, 32'(bus.uop_count), 32'd0);
        step({tag, ".launch"}, 1'b1, mul, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, Nop, 1'b0);
        cnt  = 0;
        last = (rel_at == 0) ? Timeout : rel_at;
        for (int b = 1; b <= last; b++) begin
            m  = (uop_mode == 2) ? 1'b1 : (uop_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            ui = $urandom;
            r  = (b == rel_at);
            ab = (rel_at == 0) && (b == Timeout);
            if (m) cnt++;
            step({tag, ".busy"}, 1'b1, mul, m, ui, r, 1'b1, 1'b0, ab, m ? ui : Nop, m);
        end
        if (rel_at == 0) begin
            e_to = 1'b1;
        end else begin
            for (int d = 0; d < Drain; d++) begin
                step({tag, ".drain"}, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0,
                     Nop, 1'b0);
            end
        end
        chk({tag, ".uop_count"}, 32'(bus.uop_count), 32'(cnt));
        chk({tag, ".mul_hold"}, bus.mul_instr, mul);
        chk_flags(tag);
    endtask

    task automatic step_idle(input string tag);
        step(tag, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, Nop, 1'b0);
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.id_instr", bus.id_instr, Nop);
        chk("rst.id_valid", 32'(bus.id_valid), 32'd0);
        chk("rst.mul_instr", bus.mul_instr, 32'd0);
        chk("rst.uop_count", 32'(bus.uop_count), 32'd0);
        chk("rst.pc_stall", 32'(bus.pc_stall), 32'd0);
        chk("rst.ucode_start", 32'(bus.ucode_start), 32'd0);
        chk_flags("rst");
        rst = 1'b0;
        tick();

        // Plain op stream passes straight through with one cycle of latency.
        for (int i = 0; i < 3; i++) begin
            w = rand_plain();
            step("plain", 1'b1, w, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, w, 1'b1);
        end
        step_idle("plain.gap");

        // Four micro-ops, the last coinciding with release.
        run_mul("mul4", 4, 2);
        step_idle("mul4.idle");
        // Release two cycles after start, no micro-ops.
        run_mul("imm0", 2, 0);
        step_idle("imm0.idle");
        // Random micro-op patterns and release points.
        for (int k = 0; k < 3; k++) begin
            run_mul("rnd", int'($urandom_range(1, Timeout - 1)), 1);
            step_idle("rnd.idle");
        end
        // Release on the watchdog's final cycle: drain, no abort.
        run_mul("rel_last", Timeout, 1);
        step_idle("rel_last.idle");
        // Silent sequencer: abort on the last BUSY cycle, slot back to IF at once.
        run_mul("tmo", 0, 1);
        step_idle("tmo.idle");
        chk_flags("tmo.after");

        // Release while idle: ignored by ID, flagged as spurious.
        w = rand_plain();
        step("spur.prev", 1'b1, w, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, w, 1'b1);
        step("spur", 1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, Nop, 1'b0);
        e_sp = 1'b1;
        chk_flags("spur");
        step_idle("spur.idle");

        // Back-to-back MULs: the second is fetched in the first idle cycle after drain.
        run_mul("b2b0", 3, 1);
        run_mul("b2b1", 2, 1);
        step_idle("b2b.idle");

        // Asynchronous reset in the middle of a sequence.
        w = rand_mul();
        step("mid.detect", 1'b1, w, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, Nop, 1'b0);
        step("mid.launch", 1'b1, w, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, Nop, 1'b0);
        step("mid.busy", 1'b1, w, 1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 1'b0,
             32'hA5A5_0001, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        tick();
        e_to = 1'b0;
        e_sp = 1'b0;
        chk("mid.busy_q", 32'(bus.busy), 32'd0);
        chk("mid.pc_stall", 32'(bus.pc_stall), 32'd0);
        chk("mid.id_instr", bus.id_instr, Nop);
        chk("mid.uop_count", 32'(bus.uop_count), 32'd0);
        chk_flags("mid");
        rst = 1'b0;
        step_idle("mid.idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
